// File: rtl/umi_mux_pkg.sv
// Shared UMI definitions: command field layout and arbitration mode encodings.
package umi_mux_pkg;

  // Bit position of the end-of-message flag inside a UMI command word.
  localparam int UMI_EOM_BIT = 22;

  // Low 32 bits of a UMI command word. The named fields give their positions:
  // opcode [4:0], size [7:5], len [15:8], eom [22].
  typedef struct packed {
    logic [8:0] rsvd_hi;
    logic       eom;
    logic [5:0] rsvd_mid;
    logic [7:0] len;
    logic [2:0] size;
    logic [4:0] opcode;
  } umi_cmd_t;

  // arbmode encodings; the two round-robin and the two fixed codes behave identically.
  localparam logic [1:0] ARB_FIXED     = 2'b00;
  localparam logic [1:0] ARB_RR        = 2'b01;
  localparam logic [1:0] ARB_RR_ALT    = 2'b10;
  localparam logic [1:0] ARB_FIXED_ALT = 2'b11;

  function automatic logic arb_is_rr(input logic [1:0] mode);
    logic rr;
    case (mode)
      ARB_RR, ARB_RR_ALT:       rr = 1'b1;
      ARB_FIXED, ARB_FIXED_ALT: rr = 1'b0;
      default:                  rr = 1'b0;
    endcase
    return rr;
  endfunction

endpackage

// File: rtl/umi_arbiter.sv
// One-hot arbiter for the UMI mux: fixed or round-robin priority, packet lock
// from a non-EOM beat until the EOM beat, and grant hold while the output stalls.
module umi_arbiter
  import umi_mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [1:0]   arbmode,
  input  logic [N-1:0] arbmask,
  input  logic [N-1:0] valid,
  input  logic [N-1:0] eom,
  input  logic         ready,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  arb_grant;
  logic [N-1:0]  hold_grant;
  logic          pkt_lock;
  logic          stall_hold;
  logic [PW-1:0] ptr;
  logic [PW-1:0] start;
  logic [PW-1:0] idx;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] ptr_next;
  logic          found;
  logic          xfer;
  logic          xfer_eom;

  assign req      = valid & ~arbmask;
  assign xfer     = (|grant) & ready;
  assign xfer_eom = |(grant & eom);
  assign ptr_next = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;

  // Priority search: first eligible request at or after the start index, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    arb_grant = '0;
    found     = 1'b0;
    idx       = '0;
    start     = arb_is_rr(arbmode) ? ptr : '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(start) + k) % N);
      if (!found && req[idx]) begin
        arb_grant[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  // Final grant: nothing in reset, the held input while locked or stalled, else the search.
  always_comb begin
    if (nreset) begin
      grant = '0;
    end else if (pkt_lock || stall_hold) begin
      grant = hold_grant & valid;
    end else begin
      grant = arb_grant;
    end
  end

  // Encode the one-hot grant so the round-robin pointer can step past the winner.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

  // Lock, stall-hold and round-robin pointer state.
  always_ff @(posedge clk or posedge nreset) begin
    // NOTE: hold_grant is reset along with the flags so a stale grant can never
    // be replayed after reset, even though the flags alone would mask it.
    if (nreset) begin
      pkt_lock   <= 1'b0;
      stall_hold <= 1'b0;
      hold_grant <= '0;
      ptr        <= '0;
    end else if (xfer) begin
      // NOTE: sequential state uses non-blocking assignment so all updates see pre-edge values.
      stall_hold <= 1'b0;
      if (xfer_eom) begin
        pkt_lock <= 1'b0;
        if (arb_is_rr(arbmode)) ptr <= ptr_next;
      end else begin
        pkt_lock   <= 1'b1;
        hold_grant <= grant;
      end
    end else if (|grant) begin
      // Valid presented but not accepted: keep this input until it is taken.
      stall_hold <= 1'b1;
      hold_grant <= grant;
    end else begin
      stall_hold <= 1'b0;
    end
  end

endmodule

// File: rtl/umi_mux.sv
// N-to-1 UMI multiplexer: zero-latency one-hot select datapath and ready fan-out;
// arbitration lives in umi_arbiter.
module umi_mux
  import umi_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 256,
  parameter int CW = 32,
  parameter int AW = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [1:0]      arbmode,
  input  logic [N-1:0]    arbmask,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready
);

  logic [N-1:0] grant;
  logic [N-1:0] eom;

  // Per-input end-of-message flags for the arbiter's lock logic.
  always_comb begin
    eom = '0;
    for (int i = 0; i < N; i++) begin
      eom[i] = umi_in_cmd[i*CW + UMI_EOM_BIT];
    end
  end

  umi_arbiter #(.N(N)) u_arbiter (
    .clk     (clk),
    .nreset  (nreset),
    .arbmode (arbmode),
    .arbmask (arbmask),
    .valid   (umi_in_valid),
    .eom     (eom),
    .ready   (umi_out_ready),
    .grant   (grant)
  );

  assign umi_out_valid = |grant;
  assign umi_in_ready  = grant & {N{umi_out_ready}};

  // AND-OR select of the granted input's fields; all zero when nothing is granted.
  always_comb begin
    umi_out_cmd     = '0;
    umi_out_dstaddr = '0;
    umi_out_srcaddr = '0;
    umi_out_data    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        umi_out_cmd     = umi_out_cmd     | umi_in_cmd[i*CW +: CW];
        umi_out_dstaddr = umi_out_dstaddr | umi_in_dstaddr[i*AW +: AW];
        umi_out_srcaddr = umi_out_srcaddr | umi_in_srcaddr[i*AW +: AW];
        umi_out_data    = umi_out_data    | umi_in_data[i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_umi_mux.sv
// Directed and randomized-traffic bench for umi_mux (N=4, narrow fields).
module tb_umi_mux;
  import umi_mux_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            nreset;
  logic [1:0]      arbmode;
  logic [N-1:0]    arbmask;
  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  umi_mux #(.N(N), .DW(DW), .CW(CW), .AW(AW)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .arbmode         (arbmode),
    .arbmask         (arbmask),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_cmd(input int src, input logic eom, input logic [31:0] tag);
    umi_cmd_t c;
    c        = '0;
    c.opcode = 5'(src);
    c.size   = 3'd3;
    c.len    = tag[7:0];
    c.eom    = eom;
    return c;
  endfunction

  function automatic logic [DW-1:0] mk_data(input int src, input logic [31:0] tag);
    return {32'(src), tag};
  endfunction

  // Present a beat on input src (valid is driven separately).
  task automatic drive(input int src, input logic eom, input logic [31:0] tag);
    umi_in_cmd[src*CW +: CW]     = mk_cmd(src, eom, tag);
    umi_in_dstaddr[src*AW +: AW] = 32'hD000_0000 + tag;
    umi_in_srcaddr[src*AW +: AW] = 32'h5000_0000 + tag;
    umi_in_data[src*DW +: DW]    = mk_data(src, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int next_seq [N];
  int rem      [N];
  int exp_seq  [N];
  logic [N-1:0] pres;
  int open_src;
  int src;
  logic [31:0] seq;

  initial begin
    nreset         = 1'b1;
    arbmode        = ARB_FIXED;
    arbmask        = '0;
    umi_in_valid   = '0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 1'b1, 32'h10 + 32'(i));
    umi_in_valid = 4'b1111;

    // Reset holds the outputs quiet even with every input valid.
    #1;
    check("reset_out_valid", 64'(umi_out_valid), 64'd0);
    check("reset_in_ready", 64'(umi_in_ready), 64'd0);
    tick();
    tick();
    nreset = 1'b0;

    // Fixed priority, valid 1010: input 1 wins.
    arbmode      = ARB_FIXED;
    umi_in_valid = 4'b1010;
    #1;
    check("fixed_out_valid", 64'(umi_out_valid), 64'd1);
    check("fixed_in_ready", 64'(umi_in_ready), 64'b0010);
    check("fixed_out_cmd", 64'(umi_out_cmd), 64'(mk_cmd(1, 1'b1, 32'h11)));
    check("fixed_out_data", 64'(umi_out_data), 64'(mk_data(1, 32'h11)));
    check("fixed_out_dst", 64'(umi_out_dstaddr), 64'(32'hD000_0011));
    check("fixed_out_src", 64'(umi_out_srcaddr), 64'(32'h5000_0011));
    tick();

    // Round-robin (code 10), all valid: 0,1,2,3,0.
    arbmode      = ARB_RR_ALT;
    umi_in_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("rr_in_ready", 64'(umi_in_ready), 64'd1 << (c % 4));
      check("rr_out_data", 64'(umi_out_data), 64'(mk_data(c % 4, 32'h10 + 32'(c % 4))));
      tick();
    end

    // Pointer is now 1. Input 2 sends a 3-beat packet while input 0 waits;
    // mid-packet the mode goes fixed and input 2 gets masked, the lock must hold.
    arbmode      = ARB_RR;
    umi_in_valid = 4'b0101;
    drive(2, 1'b0, 32'h20);
    drive(0, 1'b1, 32'h30);
    #1;
    check("pkt_beat0_ready", 64'(umi_in_ready), 64'b0100);
    check("pkt_beat0_cmd", 64'(umi_out_cmd), 64'(mk_cmd(2, 1'b0, 32'h20)));
    tick();
    drive(2, 1'b0, 32'h21);
    arbmode = ARB_FIXED;
    arbmask = 4'b0100;
    #1;
    check("pkt_beat1_ready", 64'(umi_in_ready), 64'b0100);
    check("pkt_beat1_data", 64'(umi_out_data), 64'(mk_data(2, 32'h21)));
    tick();
    drive(2, 1'b1, 32'h22);
    arbmode = ARB_RR;
    arbmask = 4'b0000;
    #1;
    check("pkt_beat2_ready", 64'(umi_in_ready), 64'b0100);
    check("pkt_beat2_cmd", 64'(umi_out_cmd), 64'(mk_cmd(2, 1'b1, 32'h22)));
    tick();
    umi_in_valid = 4'b0001;
    #1;
    check("pkt_after_ready", 64'(umi_in_ready), 64'b0001);
    check("pkt_after_cmd", 64'(umi_out_cmd), 64'(mk_cmd(0, 1'b1, 32'h30)));
    tick();

    // Locked input drops valid: output goes idle, nobody else is granted.
    arbmode      = ARB_FIXED;
    umi_in_valid = 4'b0010;
    drive(1, 1'b0, 32'h40);
    #1;
    check("lock_start_ready", 64'(umi_in_ready), 64'b0010);
    tick();
    umi_in_valid = 4'b1001;
    drive(0, 1'b1, 32'h41);
    drive(3, 1'b1, 32'h42);
    #1;
    check("lock_gap_valid", 64'(umi_out_valid), 64'd0);
    check("lock_gap_ready", 64'(umi_in_ready), 64'd0);
    tick();
    umi_in_valid = 4'b1011;
    drive(1, 1'b1, 32'h43);
    #1;
    check("lock_end_ready", 64'(umi_in_ready), 64'b0010);
    check("lock_end_cmd", 64'(umi_out_cmd), 64'(mk_cmd(1, 1'b1, 32'h43)));
    tick();
    umi_in_valid = 4'b1001;
    #1;
    check("lock_release_ready", 64'(umi_in_ready), 64'b0001);
    tick();

    // Masked-only request: output idle and fields driven to zero.
    umi_in_valid = 4'b0001;
    arbmask      = 4'b0001;
    #1;
    check("mask_out_valid", 64'(umi_out_valid), 64'd0);
    check("mask_in_ready", 64'(umi_in_ready), 64'd0);
    check("mask_out_cmd", 64'(umi_out_cmd), 64'd0);
    check("mask_out_data", 64'(umi_out_data), 64'd0);
    tick();
    arbmask = 4'b0000;

    // Output stall for 5 cycles; a higher-priority input appears mid-stall.
    umi_in_valid  = 4'b0100;
    umi_out_ready = 1'b0;
    drive(2, 1'b1, 32'h50);
    drive(0, 1'b1, 32'h51);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) umi_in_valid = 4'b0101;
      #1;
      check("stall_out_valid", 64'(umi_out_valid), 64'd1);
      check("stall_in_ready", 64'(umi_in_ready), 64'd0);
      check("stall_out_cmd", 64'(umi_out_cmd), 64'(mk_cmd(2, 1'b1, 32'h50)));
      check("stall_out_data", 64'(umi_out_data), 64'(mk_data(2, 32'h50)));
      tick();
    end
    umi_out_ready = 1'b1;
    #1;
    check("stall_release_ready", 64'(umi_in_ready), 64'b0100);
    check("stall_release_data", 64'(umi_out_data), 64'(mk_data(2, 32'h50)));
    tick();
    umi_in_valid = 4'b0001;
    #1;
    check("stall_next_ready", 64'(umi_in_ready), 64'b0001);
    tick();

    // Reset mid-packet discards the lock; arbitration restarts at input 0.
    arbmode      = ARB_RR;
    umi_in_valid = 4'b1000;
    drive(3, 1'b0, 32'h60);
    #1;
    check("rst_pkt_ready", 64'(umi_in_ready), 64'b1000);
    tick();
    nreset       = 1'b1;
    umi_in_valid = 4'b1001;
    drive(0, 1'b1, 32'h61);
    drive(3, 1'b1, 32'h62);
    #1;
    check("rst_mid_valid", 64'(umi_out_valid), 64'd0);
    check("rst_mid_ready", 64'(umi_in_ready), 64'd0);
    tick();
    nreset = 1'b0;
    #1;
    check("rst_after_ready", 64'(umi_in_ready), 64'b0001);
    check("rst_after_cmd", 64'(umi_out_cmd), 64'(mk_cmd(0, 1'b1, 32'h61)));
    tick();
    umi_in_valid = '0;
    tick();

    // Random traffic: 4 sources, packets of 1..3 beats, random valid, ready and mode.
    for (int i = 0; i < N; i++) begin
      next_seq[i] = 0;
      rem[i]      = 0;
      exp_seq[i]  = 0;
    end
    pres     = '0;
    open_src = -1;
    for (int cyc = 0; cyc < 700; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pres[i] && (cyc < 500 || rem[i] != 0) && $urandom_range(0, 2) != 0) begin
          if (rem[i] == 0) rem[i] = int'($urandom_range(1, 3));
          drive(i, rem[i] == 1, 32'(next_seq[i]));
          pres[i] = 1'b1;
        end
      end
      umi_in_valid  = pres;
      umi_out_ready = (cyc >= 500) || ($urandom_range(0, 3) != 0);
      arbmode       = 2'($urandom_range(0, 3));
      #1;
      if (umi_out_valid && umi_out_ready) begin
        src = int'(umi_out_data[63:32]);
        seq = umi_out_data[31:0];
        check("rnd_src_range", 64'(src < N), 64'd1);
        if (src < N) begin
          check("rnd_ready", 64'(umi_in_ready), 64'd1 << src);
          check("rnd_order", 64'(seq), 64'(exp_seq[src]));
          check("rnd_dst", 64'(umi_out_dstaddr), 64'(32'hD000_0000 + seq));
          if (open_src >= 0) check("rnd_interleave", 64'(src), 64'(open_src));
          exp_seq[src]++;
          open_src = umi_out_cmd[UMI_EOM_BIT] ? -1 : src;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (umi_in_ready[i]) begin
          pres[i] = 1'b0;
          rem[i]--;
          next_seq[i]++;
        end
      end
      tick();
    end
    check("rnd_drained", 64'(pres), 64'd0);
    for (int i = 0; i < N; i++) begin
      check("rnd_count", 64'(exp_seq[i]), 64'(next_seq[i]));
      check("rnd_pkt_done", 64'(rem[i]), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/umi_mux.md
UMI_MUX -- requirements
Module: umi_mux

Interface
REQ-001 Parameter N, default 4: number of UMI input ports, N >= 2.
REQ-002 Parameter DW, default 256: data width in bits.
REQ-003 Parameter CW, default 32: command width in bits.
REQ-004 Parameter AW, default 64: address width in bits.
REQ-005 clk  in  1: single clock; all state is on its rising edge.
REQ-006 nreset  in  1: asynchronous, active-high reset (asserted = 1).
REQ-007 arbmode  in  2: 00 fixed priority (lowest index wins), 01 round-robin, 10 round-robin, 11 fixed priority.
REQ-008 arbmask  in  N: bit i = 1 excludes input i from arbitration.
REQ-009 umi_in_valid  in  N: per-input valid.
REQ-010 umi_in_cmd  in  N*CW: input i occupies [i*CW +: CW].
REQ-011 umi_in_dstaddr  in  N*AW, and umi_in_srcaddr  in  N*AW: input i occupies [i*AW +: AW].
REQ-012 umi_in_data  in  N*DW: input i occupies [i*DW +: DW].
REQ-013 umi_in_ready  out  N: per-input ready.
REQ-014 umi_out_valid  out  1; umi_out_cmd  out  CW; umi_out_dstaddr  out  AW; umi_out_srcaddr  out  AW; umi_out_data  out  DW; umi_out_ready  in  1.

Function
REQ-015 Eligible requests: req[i] = umi_in_valid[i] & ~arbmask[i].
REQ-016 Exactly one input (or none) is granted per cycle; the grant is one-hot.
REQ-017 The datapath is combinational, zero cycles of latency: granted input's cmd/dstaddr/srcaddr/data drive the outputs; umi_out_valid = OR of granted req.
REQ-018 umi_in_ready[i] = grant[i] & umi_out_ready; ungranted inputs see ready 0.
REQ-019 A beat transfers when umi_out_valid & umi_out_ready are both 1 in a cycle.
REQ-020 Packet lock: once a beat with cmd[22] (EOM) = 0 transfers, the grant stays on that input until a beat with EOM = 1 transfers, regardless of other requests, arbmode or arbmask changes.
REQ-021 While locked and the locked input drops valid, umi_out_valid = 0 and no other input is granted.
REQ-022 Round-robin: the priority pointer advances to (winner+1) mod N only on a transferred EOM = 1 beat; search begins at the pointer, wrapping from N-1 to 0.
REQ-023 Fixed priority: the lowest-index eligible request wins; no pointer is used.
REQ-024 With no eligible request and no lock, umi_out_valid = 0, all umi_in_ready = 0, and the output fields are don't-care (driven 0).
REQ-025 Output fields hold stable while umi_out_valid = 1 and umi_out_ready = 0 provided the granted input holds stable (no re-arbitration mid-stall once valid is presented).

Reset
REQ-026 While nreset = 1: lock cleared, round-robin pointer = 0, umi_out_valid = 0, umi_in_ready = 0.
REQ-027 Reset asserted mid-packet discards the lock; after release, arbitration restarts from input 0.

Structure
REQ-028 A shared package holds UMI cmd field positions (EOM bit = 22, opcode [4:0], size [7:5], len [15:8]) and arbmode encodings.
REQ-029 Arbitration (priority, round-robin pointer, lock) lives in one sub-module umi_arbiter; umi_mux holds only the one-hot select datapath and ready fan-out.

Verification
REQ-030 arbmode=00, valid=4'b1010, all EOM=1, out_ready=1 -> input 1 granted, in_ready=4'b0010, out_cmd = input 1 cmd.
REQ-031 arbmode=10, valid=4'b1111 held, all EOM=1 -> grants 0,1,2,3,0 on successive cycles.
REQ-032 arbmode=01, input 2 sends 3 beats (EOM 0,0,1) while input 0 stays valid -> all 3 beats from input 2 before input 0 is granted.
REQ-033 arbmask=4'b0001, valid=4'b0001 -> umi_out_valid=0, in_ready=0.
REQ-034 out_ready=0 for 5 cycles with valid=4'b0100 -> out_valid=1, fields constant, in_ready=0; transfer on first ready cycle.
REQ-035 Four random-traffic sources with random valid/ready throttling -> every input beat appears exactly once at the output, per-input order preserved, no packet interleaving.
